// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: widths, timeout default, FSM encoding.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned REG_W       = 3;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts bus wait cycles; expired flags the cycle on which the TIMEOUT-th wait cycle occurs.
module mem_wait_timer
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count enabled cycles, saturating at TIMEOUT; clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Wait-count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current enabled cycle is the TIMEOUT-th one.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: passes ALU results to WB in one cycle, runs a held bus
// request for loads/stores with a bounded wait and a sticky timeout flag.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_EX,
    input  logic [DATA_W-1:0] alu_result_EX,
    input  logic [DATA_W-1:0] store_data_EX,
    input  logic [REG_W-1:0]  rd_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              RegWrite_EX,
    input  logic              ResultSrc_EX,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_mem,
    output logic              valid_WB,
    output logic              RegWrite_WB,
    output logic              ResultSrc_WB,
    output logic [REG_W-1:0]  rd_WB,
    output logic [DATA_W-1:0] alu_result_WB,
    output logic [DATA_W-1:0] mem_data_WB,
    output logic              mem_err
);

    state_e state_q, state_d;

    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              valid_wb_q,  valid_wb_d;
    logic              regw_wb_q,   regw_wb_d;
    logic              rsrc_wb_q,   rsrc_wb_d;
    logic [REG_W-1:0]  rd_wb_q,     rd_wb_d;
    logic [DATA_W-1:0] alu_wb_q,    alu_wb_d;
    logic [DATA_W-1:0] mdata_wb_q,  mdata_wb_d;
    logic              mem_err_q,   mem_err_d;

    // Operation latched at the start of an access, released to WB on completion.
    logic [DATA_W-1:0] alu_lat_q,   alu_lat_d;
    logic [REG_W-1:0]  rd_lat_q,    rd_lat_d;
    logic              regw_lat_q,  regw_lat_d;
    logic              rsrc_lat_q,  rsrc_lat_d;
    logic              read_lat_q,  read_lat_d;

    logic is_mem_op;
    logic timer_en;
    logic timer_clr;
    logic timer_expired;

    assign is_mem_op = valid_EX && (MemRead_EX || MemWrite_EX);
    assign timer_en  = (state_q == ACCESS) && !mem_ready;
    assign timer_clr = (state_q == IDLE);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (timer_en),
        .clear   (timer_clr),
        .expired (timer_expired)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_wb_d  = valid_wb_q;
        regw_wb_d   = regw_wb_q;
        rsrc_wb_d   = rsrc_wb_q;
        rd_wb_d     = rd_wb_q;
        alu_wb_d    = alu_wb_q;
        mdata_wb_d  = mdata_wb_q;
        mem_err_d   = mem_err_q;
        alu_lat_d   = alu_lat_q;
        rd_lat_d    = rd_lat_q;
        regw_lat_d  = regw_lat_q;
        rsrc_lat_d  = rsrc_lat_q;
        read_lat_d  = read_lat_q;
        stall_mem   = 1'b0;

        unique case (state_q)
            IDLE: begin
                valid_wb_d = 1'b0;
                regw_wb_d  = 1'b0;
                stall_mem  = !reset && is_mem_op;
                if (is_mem_op) begin
                    state_d     = ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite_EX;
                    mem_addr_d  = ADDR_W'(alu_result_EX);
                    mem_wdata_d = store_data_EX;
                    alu_lat_d   = alu_result_EX;
                    rd_lat_d    = rd_EX;
                    // A dual-flag op is a pure store and never writes a register.
                    regw_lat_d  = RegWrite_EX && !(MemRead_EX && MemWrite_EX);
                    rsrc_lat_d  = ResultSrc_EX;
                    read_lat_d  = MemRead_EX && !MemWrite_EX;
                end else if (valid_EX) begin
                    valid_wb_d = 1'b1;
                    regw_wb_d  = RegWrite_EX;
                    rsrc_wb_d  = ResultSrc_EX;
                    rd_wb_d    = rd_EX;
                    alu_wb_d   = alu_result_EX;
                end
            end
            ACCESS: begin
                stall_mem = !reset && !mem_ready;
                if (mem_ready || timer_expired) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    valid_wb_d = 1'b1;
                    rsrc_wb_d  = rsrc_lat_q;
                    rd_wb_d    = rd_lat_q;
                    alu_wb_d   = alu_lat_q;
                    if (mem_ready) begin
                        regw_wb_d = regw_lat_q;
                        if (read_lat_q) begin
                            mdata_wb_d = mem_rdata;
                        end
                    end else begin
                        regw_wb_d = 1'b0;
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_wb_q  <= 1'b0;
            regw_wb_q   <= 1'b0;
            rsrc_wb_q   <= 1'b0;
            rd_wb_q     <= '0;
            alu_wb_q    <= '0;
            mdata_wb_q  <= '0;
            mem_err_q   <= 1'b0;
            alu_lat_q   <= '0;
            rd_lat_q    <= '0;
            regw_lat_q  <= 1'b0;
            rsrc_lat_q  <= 1'b0;
            read_lat_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_wb_q  <= valid_wb_d;
            regw_wb_q   <= regw_wb_d;
            rsrc_wb_q   <= rsrc_wb_d;
            rd_wb_q     <= rd_wb_d;
            alu_wb_q    <= alu_wb_d;
            mdata_wb_q  <= mdata_wb_d;
            mem_err_q   <= mem_err_d;
            alu_lat_q   <= alu_lat_d;
            rd_lat_q    <= rd_lat_d;
            regw_lat_q  <= regw_lat_d;
            rsrc_lat_q  <= rsrc_lat_d;
            read_lat_q  <= read_lat_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign valid_WB      = valid_wb_q;
    assign RegWrite_WB   = regw_wb_q;
    assign ResultSrc_WB  = rsrc_wb_q;
    assign rd_WB         = rd_wb_q;
    assign alu_result_WB = alu_wb_q;
    assign mem_data_WB   = mdata_wb_q;
    assign mem_err       = mem_err_q;

endmodule
